// File: rtl/ex_stage_m.sv
// Execute stage with RV32M support.
// Holds the forwarding muxes, the single-cycle ALU and branch compare, and an
// iterative multiply/divide engine. The engine stalls upstream while it runs.
// The stage drives the EX/MEM pipeline register directly.
module ex_stage_m #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int HAS_M  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   d1_i,
  input  logic [XLEN-1:0]   d2_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] r1_i,
  input  logic [REG_AW-1:0] r2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [2:0]        ex_f3_i,
  input  logic [6:0]        ex_f7_i,
  input  logic              ex_imm_sel_i,
  input  logic              ex_pc_sel_i,
  input  logic              ex_jmp_i,
  input  logic              ex_br_i,
  input  logic              ex_muldiv_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_alu_i,
  input  logic              exmem_wb_reg_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_wdata_i,
  input  logic              memwb_wb_reg_wr_i,
  output logic              stall_o,
  output logic              out_valid_o,
  output logic [XLEN-1:0]   alu_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              br_jmp_en_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } m_state_t;

  m_state_t          state;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic [XLEN-1:0]   b_r;
  logic [2:0]        f3_r;
  logic [REG_AW-1:0] rd_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic              div0_r;

  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;
  logic [XLEN-1:0]   op1;
  logic [XLEN-1:0]   op2;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic              br_taken;
  logic              stall;
  logic              signed_a;
  logic              signed_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   m_result;

  // Operand forwarding: EX/MEM has priority over MEM/WB; x0 never forwards.
  always_comb begin
    fwd1 = d1_i;
    if (exmem_wb_reg_wr_i && (exmem_rd_i != '0) && (exmem_rd_i == r1_i)) begin
      fwd1 = exmem_alu_i;
    end else if (memwb_wb_reg_wr_i && (memwb_rd_i != '0) && (memwb_rd_i == r1_i)) begin
      fwd1 = memwb_wdata_i;
    end else begin
      fwd1 = d1_i;
    end
    fwd2 = d2_i;
    if (exmem_wb_reg_wr_i && (exmem_rd_i != '0) && (exmem_rd_i == r2_i)) begin
      fwd2 = exmem_alu_i;
    end else if (memwb_wb_reg_wr_i && (memwb_rd_i != '0) && (memwb_rd_i == r2_i)) begin
      fwd2 = memwb_wdata_i;
    end else begin
      fwd2 = d2_i;
    end
  end

  assign op1   = ex_pc_sel_i  ? pc_i  : fwd1;
  assign op2   = ex_imm_sel_i ? imm_i : fwd2;
  assign shamt = op2[SHW-1:0];

  // Single-cycle ALU; jumps and branches always compute op1 + op2 as the target.
  always_comb begin
    alu_res = '0;
    if (ex_jmp_i || ex_br_i) begin
      alu_res = op1 + op2;
    end else begin
      case (ex_f3_i)
        3'b000:  alu_res = ((ex_f7_i == 7'b0100000) && !ex_imm_sel_i) ? (op1 - op2) : (op1 + op2);
        3'b001:  alu_res = op1 << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
        3'b100:  alu_res = op1 ^ op2;
        3'b101:  alu_res = (ex_f7_i == 7'b0100000) ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
        3'b110:  alu_res = op1 | op2;
        3'b111:  alu_res = op1 & op2;
        default: alu_res = '0;
      endcase
    end
  end

  // Branch condition evaluated on the forwarded register operands.
  always_comb begin
    br_taken = 1'b0;
    case (ex_f3_i)
      3'b000:  br_taken = (fwd1 == fwd2);
      3'b001:  br_taken = (fwd1 != fwd2);
      3'b100:  br_taken = ($signed(fwd1) < $signed(fwd2));
      3'b101:  br_taken = ($signed(fwd1) >= $signed(fwd2));
      3'b110:  br_taken = (fwd1 < fwd2);
      3'b111:  br_taken = (fwd1 >= fwd2);
      default: br_taken = 1'b0;
    endcase
  end

  // Stall while an M op is being accepted or iterating; flush and reset release it at once.
  always_comb begin
    stall = 1'b0;
    if ((HAS_M != 0) && !rst && !flush_i) begin
      stall = (state == S_CALC) || ((state == S_IDLE) && in_valid_i && ex_muldiv_i);
    end else begin
      stall = 1'b0;
    end
  end

  assign stall_o = stall;

  // Operand preparation: the engine works on magnitudes and fixes signs at the end.
  always_comb begin
    signed_a = !((ex_f3_i == 3'b011) || (ex_f3_i == 3'b101) || (ex_f3_i == 3'b111));
    signed_b = signed_a && (ex_f3_i != 3'b010);
    a_neg    = signed_a && fwd1[XLEN-1];
    b_neg    = signed_b && fwd2[XLEN-1];
    a_mag    = a_neg ? (~fwd1 + 1'b1) : fwd1;
    b_mag    = b_neg ? (~fwd2 + 1'b1) : fwd2;
  end

  // One iteration of shift-add multiply and restoring divide on the latched state.
  always_comb begin
    mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    rem_sh   = {hi_r, lo_r[XLEN-1]};
    div_ge   = (rem_sh >= {1'b0, b_r});
    div_diff = rem_sh[XLEN-1:0] - b_r;
  end

  // Final M result: apply sign corrections and the divide-by-zero quotient.
  always_comb begin
    prod     = {hi_r, lo_r};
    prod_s   = neg_q_r ? (~prod + 1'b1) : prod;
    m_result = '0;
    case (f3_r)
      3'b000:  m_result = prod_s[XLEN-1:0];
      3'b001:  m_result = prod_s[2*XLEN-1:XLEN];
      3'b010:  m_result = prod_s[2*XLEN-1:XLEN];
      3'b011:  m_result = prod_s[2*XLEN-1:XLEN];
      3'b100:  m_result = div0_r ? {XLEN{1'b1}} : (neg_q_r ? (~lo_r + 1'b1) : lo_r);
      3'b101:  m_result = div0_r ? {XLEN{1'b1}} : lo_r;
      3'b110:  m_result = neg_r_r ? (~hi_r + 1'b1) : hi_r;
      3'b111:  m_result = hi_r;
      default: m_result = '0;
    endcase
  end

  // Multiply/divide sequencer: latch operands, run XLEN steps, then hand off the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      b_r     <= '0;
      f3_r    <= 3'b000;
      rd_r    <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      div0_r  <= 1'b0;
    end else if (flush_i) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stall) begin
            state   <= S_CALC;
            count   <= CW'(XLEN);
            hi_r    <= '0;
            lo_r    <= a_mag;
            b_r     <= b_mag;
            f3_r    <= ex_f3_i;
            rd_r    <= rd_i;
            neg_q_r <= a_neg ^ b_neg;
            neg_r_r <= a_neg;
            div0_r  <= (fwd2 == '0);
          end
        end
        S_CALC: begin
          count <= count - 1'b1;
          if (f3_r[2]) begin
            hi_r <= div_ge ? div_diff : rem_sh[XLEN-1:0];
            lo_r <= {lo_r[XLEN-2:0], div_ge};
          end else begin
            hi_r <= mul_sum[XLEN:1];
            lo_r <= {mul_sum[0], lo_r[XLEN-1:1]};
          end
          if (count == CW'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register: bubble while stalled, M result in the hand-off cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      alu_o       <= '0;
      wdata_o     <= '0;
      rd_o        <= '0;
      br_jmp_en_o <= 1'b0;
    end else if (stall) begin
      out_valid_o <= 1'b0;
      br_jmp_en_o <= 1'b0;
    end else if (state == S_DONE) begin
      out_valid_o <= in_valid_i && !flush_i;
      alu_o       <= m_result;
      wdata_o     <= fwd2;
      rd_o        <= rd_r;
      br_jmp_en_o <= 1'b0;
    end else begin
      out_valid_o <= in_valid_i && !flush_i;
      alu_o       <= alu_res;
      wdata_o     <= fwd2;
      rd_o        <= rd_i;
      br_jmp_en_o <= in_valid_i && !flush_i && (ex_jmp_i || (ex_br_i && br_taken));
    end
  end

endmodule

// File: tb/tb_ex_stage_m.sv
// Self-checking bench for ex_stage_m: a cycle-level reference model built
// from plain arithmetic, one compare process, plus directed literal checks.
module tb_ex_stage_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush;
  logic [31:0] pc, d1, d2, imm;
  logic [4:0]  r1, r2, rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        imm_sel, pc_sel, jmp, br, muldiv;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_alu, memwb_wdata;
  logic        exmem_wr, memwb_wr;
  logic        stall, out_valid, br_jmp_en;
  logic [31:0] alu, wdata;
  logic [4:0]  rd_out;

  int n_total = 0;
  int n_pass  = 0;
  logic chk_en = 1'b0;

  ex_stage_m #(.XLEN(32), .REG_AW(5), .HAS_M(1)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .flush_i(flush),
    .pc_i(pc), .d1_i(d1), .d2_i(d2), .imm_i(imm),
    .r1_i(r1), .r2_i(r2), .rd_i(rd), .ex_f3_i(f3), .ex_f7_i(f7),
    .ex_imm_sel_i(imm_sel), .ex_pc_sel_i(pc_sel), .ex_jmp_i(jmp), .ex_br_i(br),
    .ex_muldiv_i(muldiv),
    .exmem_rd_i(exmem_rd), .exmem_alu_i(exmem_alu), .exmem_wb_reg_wr_i(exmem_wr),
    .memwb_rd_i(memwb_rd), .memwb_wdata_i(memwb_wdata), .memwb_wb_reg_wr_i(memwb_wr),
    .stall_o(stall), .out_valid_o(out_valid), .alu_o(alu), .wdata_o(wdata),
    .rd_o(rd_out), .br_jmp_en_o(br_jmp_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] d);
    if (exmem_wr && r != 5'd0 && r == exmem_rd) return exmem_alu;
    if (memwb_wr && r != 5'd0 && r == memwb_rd) return memwb_wdata;
    return d;
  endfunction

  function automatic logic [31:0] ref_alu();
    logic [31:0] a, b;
    a = pc_sel ? pc : fwd_val(r1, d1);
    b = imm_sel ? imm : fwd_val(r2, d2);
    if (jmp || br) return a + b;
    case (f3)
      3'd0: return (f7 == 7'h20 && !imm_sel) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (f7 == 7'h20) ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_taken();
    logic [31:0] a, b;
    a = fwd_val(r1, d1);
    b = fwd_val(r2, d2);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib, iq;
    sa = $signed(a); sb = $signed(b); ub = {32'd0, b};
    ia = $signed(a); ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        iq = ia / ib; return iq;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        iq = ia % ib; return iq;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  logic        exp_valid, exp_br;
  logic [31:0] exp_alu, exp_wdata, m_res;
  logic [4:0]  exp_rd, m_rd;
  int          m_left;

  // Model: next EX/MEM contents; m_left counts cycles until the M result is handed off.
  always @(posedge clk) begin
    if (rst) begin
      exp_valid <= 1'b0; exp_br <= 1'b0; exp_alu <= 32'd0; exp_wdata <= 32'd0;
      exp_rd <= 5'd0; m_left <= 0;
    end else if (flush) begin
      exp_valid <= 1'b0; exp_br <= 1'b0; m_left <= 0;
    end else if (m_left > 1) begin
      exp_valid <= 1'b0; exp_br <= 1'b0; m_left <= m_left - 1;
    end else if (m_left == 1) begin
      exp_valid <= in_valid; exp_br <= 1'b0; exp_alu <= m_res; exp_rd <= m_rd;
      exp_wdata <= fwd_val(r2, d2); m_left <= 0;
    end else if (in_valid && muldiv) begin
      m_res <= ref_m(f3, fwd_val(r1, d1), fwd_val(r2, d2));
      m_rd <= rd; m_left <= 33; exp_valid <= 1'b0; exp_br <= 1'b0;
    end else begin
      exp_valid <= in_valid; exp_alu <= ref_alu(); exp_wdata <= fwd_val(r2, d2);
      exp_rd <= rd; exp_br <= in_valid && (jmp || (br && ref_taken()));
    end
  end

  logic cmp_stall;
  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_stall = !rst && !flush && ((m_left > 1) || (m_left == 0 && in_valid && muldiv));
      chk("cyc_stall", {31'd0, stall}, {31'd0, cmp_stall});
      chk("cyc_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("cyc_brjmp", {31'd0, br_jmp_en}, {31'd0, exp_br});
      if (exp_valid) begin
        chk("cyc_alu", alu, exp_alu);
        chk("cyc_wdata", wdata, exp_wdata);
        chk("cyc_rd", {27'd0, rd_out}, {27'd0, exp_rd});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    in_valid = 1'b0; flush = 1'b0; pc = 32'd0; d1 = 32'd0; d2 = 32'd0; imm = 32'd0;
    r1 = 5'd0; r2 = 5'd0; rd = 5'd0; f3 = 3'd0; f7 = 7'd0;
    imm_sel = 1'b0; pc_sel = 1'b0; jmp = 1'b0; br = 1'b0; muldiv = 1'b0;
    exmem_rd = 5'd0; exmem_alu = 32'd0; exmem_wr = 1'b0;
    memwb_rd = 5'd0; memwb_wdata = 32'd0; memwb_wr = 1'b0;
  endtask

  task automatic alu_vec(input string nm, input logic [2:0] f, input logic [6:0] f7v,
                         input logic isel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
    clr();
    in_valid = 1'b1; f3 = f; f7 = f7v; imm_sel = isel; r1 = 5'd10; r2 = 5'd11; rd = 5'd12;
    d1 = a; d2 = b; imm = b;
    tick();
    chk(nm, alu, expv);
  endtask

  task automatic run_m(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv);
    int nst;
    clr();
    in_valid = 1'b1; muldiv = 1'b1; f7 = 7'd1; f3 = f; d1 = a; d2 = b;
    r1 = 5'd1; r2 = 5'd2; rd = 5'd9;
    nst = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!stall) break;
      nst++;
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, nst, 32'd33);
    @(posedge clk); #1;
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(nm, alu, expv);
    chk({nm, "_rd"}, {27'd0, rd_out}, 32'd9);
    clr();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    clr();
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu", alu, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // add x3,x1,x2 then add x4,x3,x3 via EX/MEM
    clr(); in_valid = 1'b1; r1 = 5'd1; r2 = 5'd2; rd = 5'd3; d1 = 32'd5; d2 = 32'd7;
    tick();
    chk("add1", alu, 32'd12);
    clr(); in_valid = 1'b1; r1 = 5'd3; r2 = 5'd3; rd = 5'd4;
    exmem_rd = 5'd3; exmem_alu = 32'd12; exmem_wr = 1'b1;
    tick();
    chk("add_fwd_exmem", alu, 32'd24);

    // both forwarding sources pending: EX/MEM wins
    clr(); in_valid = 1'b1; r1 = 5'd3; r2 = 5'd3; rd = 5'd5;
    exmem_rd = 5'd3; exmem_alu = 32'd9; exmem_wr = 1'b1;
    memwb_rd = 5'd3; memwb_wdata = 32'd4; memwb_wr = 1'b1;
    tick();
    chk("fwd_priority", alu, 32'd18);

    // MEM/WB only, x0 never forwarded
    clr(); in_valid = 1'b1; r1 = 5'd6; r2 = 5'd0; rd = 5'd7; d2 = 32'd100;
    memwb_rd = 5'd6; memwb_wdata = 32'd11; memwb_wr = 1'b1;
    exmem_rd = 5'd0; exmem_alu = 32'd55; exmem_wr = 1'b1;
    tick();
    chk("fwd_memwb_x0", alu, 32'd111);

    alu_vec("sub",  3'd0, 7'h20, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("addi", 3'd0, 7'h20, 1'b1, 32'd10, 32'hFFFF_FFFF, 32'd9);
    alu_vec("sll",  3'd1, 7'h00, 1'b0, 32'd1, 32'd31, 32'h8000_0000);
    alu_vec("slt",  3'd2, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu", 3'd3, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("xor",  3'd4, 7'h00, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
    alu_vec("srl",  3'd5, 7'h00, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_vec("sra",  3'd5, 7'h20, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000);

    // beq on equal forwarded operands
    clr(); in_valid = 1'b1; br = 1'b1; f3 = 3'd0; pc_sel = 1'b1; imm_sel = 1'b1;
    pc = 32'h100; imm = 32'h20; r1 = 5'd5; r2 = 5'd6; d1 = 32'd1; d2 = 32'd2;
    exmem_rd = 5'd5; exmem_alu = 32'd42; exmem_wr = 1'b1;
    memwb_rd = 5'd6; memwb_wdata = 32'd42; memwb_wr = 1'b1;
    tick();
    chk("beq_taken", {31'd0, br_jmp_en}, 32'd1);
    chk("beq_target", alu, 32'h120);
    chk("beq_wdata", wdata, 32'd42);
    // bne on the same operands: not taken
    f3 = 3'd1;
    tick();
    chk("bne_not_taken", {31'd0, br_jmp_en}, 32'd0);
    // bltu taken with raw register data
    clr(); in_valid = 1'b1; br = 1'b1; f3 = 3'd6; pc_sel = 1'b1; imm_sel = 1'b1;
    pc = 32'h200; imm = 32'hFFFF_FFF0; d1 = 32'd3; d2 = 32'hFFFF_FFFF; r1 = 5'd8; r2 = 5'd9;
    tick();
    chk("bltu_taken", {31'd0, br_jmp_en}, 32'd1);
    chk("bltu_target", alu, 32'h1F0);
    // invalid slot never redirects
    in_valid = 1'b0;
    tick();
    chk("br_invalid", {31'd0, br_jmp_en}, 32'd0);

    // multiply / divide
    run_m("mul",    3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    run_m("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_m("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_m("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_m("div0",   3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_m("rem0",   3'd6, 32'd7, 32'd0, 32'd7);
    run_m("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_m("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_m("divu",   3'd5, 32'd100, 32'd7, 32'd14);
    run_m("remu",   3'd7, 32'd100, 32'd7, 32'd2);
    run_m("divneg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_m("remneg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

    // flush mid-CALC
    clr(); in_valid = 1'b1; muldiv = 1'b1; f7 = 7'd1; d1 = 32'd6; d2 = 32'd7; rd = 5'd9;
    repeat (10) tick();
    clr(); flush = 1'b1;
    #1 chk("flush_stall_now", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    #1 chk("flush_stall_next", {31'd0, stall}, 32'd0);
    tick();
    run_m("after_flush", 3'd0, 32'd6, 32'd7, 32'd42);

    // reset mid-CALC
    clr(); in_valid = 1'b1; muldiv = 1'b1; f7 = 7'd1; d1 = 32'd6; d2 = 32'd7; rd = 5'd9;
    repeat (5) tick();
    clr(); rst = 1'b1;
    #1 chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_alu", alu, 32'd0);
    #1 chk("rst_mid_stall_next", {31'd0, stall}, 32'd0);
    tick();
    run_m("after_rst", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'd3);

    tick(); tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
